// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-cathode 7-segment display. It walks the digits at PRESCALE cycles per slot, with GUARD dark cycles at the start of each slot.
// Outputs are registered-only. A load is accepted when ready=1 and is committed to the display at the next frame boundary.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic                  ready,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [3:0]            dec_data,
    output logic                  blank,
    output logic                  err
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [0:0]          state_q, state_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic                err_q, err_d;
    logic                lz_q;

    logic                frame_end;
    logic                pend_bad;
    logic [DIGITS-1:0]   sup;
    logic                run_zero;
    logic [3:0]          cur_nib;
    logic                cur_sup;

    always_comb begin
        frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        state_d = (cnt_d < GUARD_C) ? ST_GUARD : ST_DRIVE;

        pend_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (pend_q[4*k +: 4] > 4'd9) pend_bad = 1'b1;
        end

        // Commit needs pend_v=1 and accept needs pend_v=0, so they never collide;
        // a load landing on the boundary edge therefore waits a full frame.
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        err_d    = err_q;
        if (frame_end && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
            err_d    = pend_bad;
        end else if (load && !pend_v_q) begin
            pend_d   = bcd_in;
            pend_v_d = 1'b1;
        end
    end

    // Leading-zero run is scanned from the most significant digit downward.
    always_comb begin
        run_zero = 1'b1;
        sup      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero = run_zero && (disp_q[4*k +: 4] == 4'd0);
            sup[k]   = ((k != 0) && lz_q && run_zero) || (disp_q[4*k +: 4] > 4'd9);
        end
        cur_nib = 4'd0;
        cur_sup = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib = disp_q[4*k +: 4];
                cur_sup = sup[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= ST_GUARD;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            err_q    <= 1'b0;
            lz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            err_q    <= err_d;
            lz_q     <= lz_en;
        end
    end

    assign ready     = ~pend_v_q;
    assign digit_sel = (state_q == ST_DRIVE) ? (DIGITS'(1) << idx_q) : '0;
    assign dec_data  = cur_nib;
    assign blank     = (state_q == ST_GUARD) || cur_sup;
    assign err       = err_q;

endmodule
